dma_prog_master: RTL and testbench

DMA_PROG_MASTER -- requirements
Module: dma_prog_master

---
 rtl/dma_prog_master_if.sv | 31 +++
 rtl/dma_prog_master.sv | 162 ++++++++++++++++
 tb/tb_dma_prog_master.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_prog_master_if.sv
// Purpose : request/response and peripheral-bus signal bundle for dma_prog_master.
// master  : DMA-programming block side (accepts requests, drives the 8-bit register bus).
// slave   : environment side (issues requests, models the DMA controller's register bus).
interface dma_prog_master_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WR;
    logic        REQ_WIDE;
    logic [3:0]  REQ_ADDR;
    logic [15:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [15:0] RSP_RDATA;
    logic        HLDA;
    logic        CS_N;
    logic        IOR_N;
    logic        IOW_N;
    logic [3:0]  ADDR_L;
    logic [7:0]  DB_OUT;
    logic        DB_OE;
    logic [7:0]  DB_IN;

    modport master (
        input  REQ_VALID, REQ_WR, REQ_WIDE, REQ_ADDR, REQ_WDATA, HLDA, DB_IN,
        output REQ_READY, RSP_VALID, RSP_RDATA, CS_N, IOR_N, IOW_N, ADDR_L, DB_OUT, DB_OE
    );

    modport slave (
        output REQ_VALID, REQ_WR, REQ_WIDE, REQ_ADDR, REQ_WDATA, HLDA, DB_IN,
        input  REQ_READY, RSP_VALID, RSP_RDATA, CS_N, IOR_N, IOW_N, ADDR_L, DB_OUT, DB_OE
    );
endinterface

// File: rtl/dma_prog_master.sv
// Purpose : turns 8/16-bit register read/write requests into timed byte cycles on a
//           DMA controller's register bus, yielding to the DMA while HLDA is high.
// Ports   : CLK, RESET (sync, active high); bus (master modport) carries the
//           REQ_* request handshake, RSP_* completion, HLDA and the CS_N/IOR_N/IOW_N/
//           ADDR_L/DB_OUT/DB_OE/DB_IN register bus.
// Params  : STROBE_CYCLES (1..4) strobe low time, CLR_FF_ADDR byte-pointer clear register.
module dma_prog_master #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter logic [3:0]  CLR_FF_ADDR   = 4'hC
) (
    input logic                CLK,
    input logic                RESET,
    dma_prog_master_if.master  bus
);
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_BUS, SETUP, STROBE, HOLD, DONE
    } state_t;

    state_t            state_q;
    logic [1:0]        idx_q;      // 0: flip-flop clear, 1: low byte, 2: high byte
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_q;
    logic              wide_q;
    logic [3:0]        addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        rd_lo_q;
    logic [7:0]        rd_hi_q;
    logic              cs_n_q;
    logic              ior_n_q;
    logic              iow_n_q;
    logic [3:0]        addr_l_q;
    logic [7:0]        db_out_q;
    logic              db_oe_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_rdata_q;

    // Attributes of the byte access selected by idx_q.
    logic       byte_wr;
    logic [3:0] byte_addr;
    logic [7:0] byte_data;
    logic       last_byte;

    always_comb begin
        byte_wr   = wr_q;
        byte_addr = addr_q;
        byte_data = wdata_q[7:0];
        last_byte = wide_q ? (idx_q == 2'd2) : 1'b1;
        if (idx_q == 2'd0) begin
            byte_wr   = 1'b1;
            byte_addr = CLR_FF_ADDR;
            byte_data = 8'h00;
        end else if (idx_q == 2'd2) begin
            byte_data = wdata_q[15:8];
        end
    end

    // Ready is gated by RESET so it is low in every reset cycle.
    assign bus.REQ_READY = (state_q == IDLE) && !RESET;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_RDATA = rsp_rdata_q;
    assign bus.CS_N      = cs_n_q;
    assign bus.IOR_N     = ior_n_q;
    assign bus.IOW_N     = iow_n_q;
    assign bus.ADDR_L    = addr_l_q;
    assign bus.DB_OUT    = db_out_q;
    assign bus.DB_OE     = db_oe_q;

    // Sequencer; bus outputs are set on the edge entering the state they belong to.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            wide_q      <= 1'b0;
            addr_q      <= 4'h0;
            wdata_q     <= 16'h0000;
            rd_lo_q     <= 8'h00;
            rd_hi_q     <= 8'h00;
            cs_n_q      <= 1'b1;
            ior_n_q     <= 1'b1;
            iow_n_q     <= 1'b1;
            addr_l_q    <= 4'h0;
            db_out_q    <= 8'h00;
            db_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.REQ_VALID) begin
                        wr_q    <= bus.REQ_WR;
                        wide_q  <= bus.REQ_WIDE;
                        addr_q  <= bus.REQ_ADDR;
                        wdata_q <= bus.REQ_WDATA;
                        idx_q   <= bus.REQ_WIDE ? 2'd0 : 2'd1;
                        rd_lo_q <= 8'h00;
                        rd_hi_q <= 8'h00;
                        state_q <= WAIT_BUS;
                    end
                end
                WAIT_BUS: begin
                    if (!bus.HLDA) begin
                        cs_n_q   <= 1'b0;
                        addr_l_q <= byte_addr;
                        db_oe_q  <= byte_wr;
                        db_out_q <= byte_wr ? byte_data : 8'h00;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    cnt_q <= '0;
                    if (byte_wr) begin
                        iow_n_q <= 1'b0;
                    end else begin
                        ior_n_q <= 1'b0;
                    end
                    state_q <= STROBE;
                end
                STROBE: begin
                    if (cnt_q == CNT_LAST) begin
                        ior_n_q <= 1'b1;
                        iow_n_q <= 1'b1;
                        // Read data is captured on the edge that ends the strobe.
                        if (!byte_wr) begin
                            if (idx_q == 2'd2) begin
                                rd_hi_q <= bus.DB_IN;
                            end else begin
                                rd_lo_q <= bus.DB_IN;
                            end
                        end
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    cs_n_q  <= 1'b1;
                    db_oe_q <= 1'b0;
                    if (last_byte) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= {rd_hi_q, rd_lo_q};
                        state_q     <= DONE;
                    end else begin
                        idx_q   <= idx_q + 2'd1;
                        state_q <= WAIT_BUS;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_prog_master.sv
// Purpose : directed self-checking bench for dma_prog_master (STROBE_CYCLES=2, CLR_FF_ADDR=C).
module tb_dma_prog_master;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dma_prog_master_if bus ();

    dma_prog_master #(.STROBE_CYCLES(2), .CLR_FF_ADDR(4'hC)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-transaction observations, one slot per CS_N low window.
    int         nwin;
    int         w_start [4];
    int         w_len   [4];
    int         w_iow   [4];
    int         w_ior   [4];
    logic [3:0] w_addr  [4];
    logic [7:0] w_data  [4];
    logic       w_oe    [4];
    int         rsp_cyc;
    logic [15:0] rsp_data;
    logic       rsp_after;
    logic       rdy_after;
    int         stab_err;
    int         ovl_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and watch the bus until one cycle past RSP_VALID (60-cycle budget).
    task automatic run_txn(input logic wr, input logic wide, input logic [3:0] addr,
                           input logic [15:0] wdata, input logic hl0, input int hl_on,
                           input int hl_off, input logic [7:0] rd0, input logic [7:0] rd1);
        int  cur;
        int  nrd;
        int  rd_idx;
        logic cs_prev;
        nwin = 0; rsp_cyc = 0; rsp_data = 16'h0; rsp_after = 1'b1; rdy_after = 1'b0;
        stab_err = 0; ovl_err = 0; nrd = 0; rd_idx = 0; cur = 0; cs_prev = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_start[i] = 0; w_len[i] = 0; w_iow[i] = 0; w_ior[i] = 0;
            w_addr[i] = 4'h0; w_data[i] = 8'h00; w_oe[i] = 1'b0;
        end
        bus.HLDA      = hl0;
        bus.REQ_VALID = 1'b1;
        bus.REQ_WR    = wr;
        bus.REQ_WIDE  = wide;
        bus.REQ_ADDR  = addr;
        bus.REQ_WDATA = wdata;
        step();
        // Scramble request inputs to show the block works from its latched copy.
        bus.REQ_VALID = 1'b0;
        bus.REQ_WR    = ~wr;
        bus.REQ_WIDE  = ~wide;
        bus.REQ_ADDR  = 4'hF;
        bus.REQ_WDATA = 16'hFFFF;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == hl_on)  bus.HLDA = 1'b1;
            if (k == hl_off) bus.HLDA = 1'b0;
            if (rsp_cyc != 0) begin
                rsp_after = bus.RSP_VALID;
                rdy_after = bus.REQ_READY;
                break;
            end
            if (!bus.IOR_N && !bus.IOW_N) ovl_err++;
            bus.DB_IN = 8'hEE;
            if (!bus.CS_N) begin
                if (cs_prev) begin
                    cur = (nwin < 4) ? nwin : 3;
                    nwin++;
                    w_start[cur] = k;
                    w_addr[cur]  = bus.ADDR_L;
                    w_data[cur]  = bus.DB_OUT;
                    w_oe[cur]    = bus.DB_OE;
                    if (!bus.DB_OE) begin
                        rd_idx = nrd;
                        nrd++;
                    end
                end else if (bus.ADDR_L !== w_addr[cur] || bus.DB_OE !== w_oe[cur] ||
                             (bus.DB_OE && bus.DB_OUT !== w_data[cur])) begin
                    stab_err++;
                end
                w_len[cur]++;
                if (!bus.IOW_N) w_iow[cur]++;
                if (!bus.IOR_N) begin
                    w_ior[cur]++;
                    bus.DB_IN = (rd_idx == 0) ? rd0 : rd1;
                end
            end else if (bus.DB_OE || !bus.IOR_N || !bus.IOW_N) begin
                stab_err++;
            end
            cs_prev = bus.CS_N;
            if (bus.RSP_VALID) begin
                rsp_cyc  = k;
                rsp_data = bus.RSP_RDATA;
            end
        end
    endtask

    task automatic check_common(input string tag);
        check({tag, "_stable"},   32'(stab_err), 32'd0);
        check({tag, "_overlap"},  32'(ovl_err), 32'd0);
        check({tag, "_rsp_once"}, 32'(rsp_after), 32'd0);
        check({tag, "_rdy_back"}, 32'(rdy_after), 32'd1);
    endtask

    initial begin
        logic saw_rsp;
        logic saw_cs;
        rst = 1'b1;
        bus.REQ_VALID = 1'b0; bus.REQ_WR = 1'b0; bus.REQ_WIDE = 1'b0;
        bus.REQ_ADDR = 4'h0; bus.REQ_WDATA = 16'h0; bus.HLDA = 1'b0; bus.DB_IN = 8'h00;

        // Reset state.
        step(); step();
        check("rst_cs_n",   32'(bus.CS_N), 32'd1);
        check("rst_ior_n",  32'(bus.IOR_N), 32'd1);
        check("rst_iow_n",  32'(bus.IOW_N), 32'd1);
        check("rst_addr",   32'(bus.ADDR_L), 32'd0);
        check("rst_dbout",  32'(bus.DB_OUT), 32'd0);
        check("rst_dboe",   32'(bus.DB_OE), 32'd0);
        check("rst_rspv",   32'(bus.RSP_VALID), 32'd0);
        check("rst_rdata",  32'(bus.RSP_RDATA), 32'd0);
        check("rst_ready",  32'(bus.REQ_READY), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(bus.REQ_READY), 32'd1);

        // Narrow write 0x55 to address 8.
        run_txn(1'b1, 1'b0, 4'h8, 16'h0055, 1'b0, -1, -1, 8'h00, 8'h00);
        check("nw_windows", 32'(nwin), 32'd1);
        check("nw_start",   32'(w_start[0]), 32'd1);
        check("nw_cs_len",  32'(w_len[0]), 32'd4);
        check("nw_iow_len", 32'(w_iow[0]), 32'd2);
        check("nw_ior_len", 32'(w_ior[0]), 32'd0);
        check("nw_addr",    32'(w_addr[0]), 32'h8);
        check("nw_data",    32'(w_data[0]), 32'h55);
        check("nw_oe",      32'(w_oe[0]), 32'd1);
        check("nw_rsp_cyc", 32'(rsp_cyc), 32'd5);
        check_common("nw");

        // Narrow read from address 3 returns {00, byte}.
        run_txn(1'b0, 1'b0, 4'h3, 16'h0000, 1'b0, -1, -1, 8'h5A, 8'h00);
        check("nr_windows", 32'(nwin), 32'd1);
        check("nr_addr",    32'(w_addr[0]), 32'h3);
        check("nr_ior_len", 32'(w_ior[0]), 32'd2);
        check("nr_iow_len", 32'(w_iow[0]), 32'd0);
        check("nr_oe",      32'(w_oe[0]), 32'd0);
        check("nr_rsp_cyc", 32'(rsp_cyc), 32'd5);
        check("nr_rdata",   32'(rsp_data), 32'h005A);
        check_common("nr");

        // Wide read from address 1: clear-FF write, then low 34, high 12.
        run_txn(1'b0, 1'b1, 4'h1, 16'h0000, 1'b0, -1, -1, 8'h34, 8'h12);
        check("wr_windows",  32'(nwin), 32'd3);
        check("wr_clr_addr", 32'(w_addr[0]), 32'hC);
        check("wr_clr_data", 32'(w_data[0]), 32'h00);
        check("wr_clr_iow",  32'(w_iow[0]), 32'd2);
        check("wr_lo_start", 32'(w_start[1]), 32'd6);
        check("wr_lo_addr",  32'(w_addr[1]), 32'h1);
        check("wr_lo_ior",   32'(w_ior[1]), 32'd2);
        check("wr_hi_start", 32'(w_start[2]), 32'd11);
        check("wr_hi_addr",  32'(w_addr[2]), 32'h1);
        check("wr_hi_ior",   32'(w_ior[2]), 32'd2);
        check("wr_rsp_cyc",  32'(rsp_cyc), 32'd15);
        check("wr_rdata",    32'(rsp_data), 32'h1234);
        check_common("wr");

        // HLDA high at acceptance, released after 10 cycles.
        run_txn(1'b1, 1'b0, 4'h6, 16'h0077, 1'b1, -1, 10, 8'h00, 8'h00);
        check("hl_windows", 32'(nwin), 32'd1);
        check("hl_start",   32'(w_start[0]), 32'd11);
        check("hl_data",    32'(w_data[0]), 32'h77);
        check("hl_rsp_cyc", 32'(rsp_cyc), 32'd15);
        check_common("hl");

        // Wide write ABCD; HLDA rises during the low-byte strobe for 5 cycles.
        run_txn(1'b1, 1'b1, 4'h2, 16'hABCD, 1'b0, 7, 12, 8'h00, 8'h00);
        check("ww_windows",  32'(nwin), 32'd3);
        check("ww_clr_addr", 32'(w_addr[0]), 32'hC);
        check("ww_lo_start", 32'(w_start[1]), 32'd6);
        check("ww_lo_len",   32'(w_len[1]), 32'd4);
        check("ww_lo_iow",   32'(w_iow[1]), 32'd2);
        check("ww_lo_addr",  32'(w_addr[1]), 32'h2);
        check("ww_lo_data",  32'(w_data[1]), 32'hCD);
        check("ww_hi_start", 32'(w_start[2]), 32'd13);
        check("ww_hi_data",  32'(w_data[2]), 32'hAB);
        check("ww_rsp_cyc",  32'(rsp_cyc), 32'd17);
        check_common("ww");

        // Reset during the strobe of a write aborts it silently.
        bus.HLDA = 1'b0;
        bus.REQ_VALID = 1'b1; bus.REQ_WR = 1'b1; bus.REQ_WIDE = 1'b0;
        bus.REQ_ADDR = 4'h5; bus.REQ_WDATA = 16'h00A5;
        step();
        bus.REQ_VALID = 1'b0;
        step(); step();
        check("ab_in_strobe", 32'(bus.IOW_N), 32'd0);
        rst = 1'b1;
        step();
        check("ab_iow_n",  32'(bus.IOW_N), 32'd1);
        check("ab_cs_n",   32'(bus.CS_N), 32'd1);
        check("ab_dboe",   32'(bus.DB_OE), 32'd0);
        check("ab_rspv",   32'(bus.RSP_VALID), 32'd0);
        check("ab_ready0", 32'(bus.REQ_READY), 32'd0);
        rst = 1'b0;
        #1;
        check("ab_ready1", 32'(bus.REQ_READY), 32'd1);
        saw_rsp = 1'b0;
        saw_cs  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.RSP_VALID) saw_rsp = 1'b1;
            if (!bus.CS_N) saw_cs = 1'b1;
        end
        check("ab_no_rsp",  32'(saw_rsp), 32'd0);
        check("ab_no_cs",   32'(saw_cs), 32'd0);
        check("ab_idle_rdy", 32'(bus.REQ_READY), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
